// File: rtl/real_window_avg_if.sv
// Sample stream in, window statistics out, for the real_window_avg stage.
// The producer side uses master; real_window_avg takes slave.
interface real_window_avg_if #(
  parameter int WIDTH = 25
);
  logic                    clear;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_avg;
  logic signed [WIDTH-1:0] out_min;
  logic signed [WIDTH-1:0] out_max;
  logic                    out_full;

  modport master (
    output clear, in_valid, in_data,
    input  out_valid, out_avg, out_min, out_max, out_full
  );

  modport slave (
    input  clear, in_valid, in_data,
    output out_valid, out_avg, out_min, out_max, out_full
  );
endinterface

// File: rtl/real_window_avg.sv
// Sliding-window average/min/max over the last DEPTH fixed-point samples.
// Window state updates on the accepting edge; the statistics are registered one edge later.
module real_window_avg #(
  parameter int WIDTH    = 25,
  parameter int EXPONENT = -16,
  parameter int DEPTH    = 4
) (
  input logic              clk,
  input logic              rst,
  real_window_avg_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = WIDTH + AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("real_window_avg: DEPTH must be a power of two in 2..16");
  end
  if (EXPONENT < -1024 || EXPONENT > 1024) begin : g_bad_exponent
    $error("real_window_avg: EXPONENT out of range");
  end

  typedef enum logic {FILL, RUN} state_t;

  state_t                  state, state_nx;
  logic signed [WIDTH-1:0] ring [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW:0]             count, count_nx;
  logic signed [SW-1:0]    sum, sum_nx;
  logic                    pend, pend_nx;
  logic                    flush, accept;
  logic signed [WIDTH-1:0] evicted, avg_nx, win_min, win_max;

  assign flush  = rst | bus.clear;
  assign accept = bus.in_valid & ~flush;

  always_ff @(posedge clk) begin
    if (flush) state <= FILL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    count_nx = (count == FULL_CNT) ? count : count + 1'b1;
    if (accept && count_nx == FULL_CNT) state_nx = RUN;
  end

  always_comb begin
    evicted = (state == RUN) ? ring[wr_ptr] : '0;
    sum_nx  = sum + {{AW{bus.in_data[WIDTH-1]}}, bus.in_data}
                  - {{AW{evicted[WIDTH-1]}}, evicted};
    pend_nx = accept && (count_nx == FULL_CNT);
    // pend marks a full-window update made on the previous edge; stats read the updated ring/sum
    avg_nx  = WIDTH'(sum >>> AW);
    win_min = ring[0];
    win_max = ring[0];
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (ring[i] < win_min) win_min = ring[i];
      if (ring[i] > win_max) win_max = ring[i];
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      ring          <= '{default: '0};
      wr_ptr        <= '0;
      count         <= '0;
      sum           <= '0;
      pend          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_full  <= 1'b0;
      bus.out_avg   <= '0;
      bus.out_min   <= '0;
      bus.out_max   <= '0;
    end else begin
      pend          <= pend_nx;
      bus.out_valid <= pend;
      bus.out_full  <= (state == RUN);
      if (accept) begin
        ring[wr_ptr] <= bus.in_data;
        wr_ptr       <= wr_ptr + 1'b1;
        count        <= count_nx;
        sum          <= sum_nx;
      end
      if (pend) begin
        bus.out_avg <= avg_nx;
        bus.out_min <= win_min;
        bus.out_max <= win_max;
      end
    end
  end
endmodule

// File: tb/tb_real_window_avg.sv
// Directed bench for real_window_avg (WIDTH=25, EXPONENT=-16, DEPTH=4).
// Inputs change on the falling edge; each sample shows up in the outputs two falling edges later.
module tb_real_window_avg;
  localparam int WIDTH    = 25;
  localparam int EXPONENT = -16;
  localparam int DEPTH    = 4;
  localparam int ONE      = 65536;
  localparam int MAXP     = 16777215;
  localparam int MINN     = -16777216;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  real_window_avg_if #(.WIDTH(WIDTH)) bus ();

  real_window_avg #(.WIDTH(WIDTH), .EXPONENT(EXPONENT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input logic v, input int d, input logic c, input logic r);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d[WIDTH-1:0];
    bus.clear    = c;
    rst          = r;
  endtask

  task automatic push(input int d);
    tick(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    tick(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic chk_stats(input string tag, input int v, input int avg, input int mn, input int mx);
    chk({tag, "_valid"}, int'(bus.out_valid), v);
    chk({tag, "_avg"},   int'(bus.out_avg),   avg);
    chk({tag, "_min"},   int'(bus.out_min),   mn);
    chk({tag, "_max"},   int'(bus.out_max),   mx);
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.clear    = 1'b0;
    tick(1'b0, 0, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    idle();
    chk_stats("reset", 0, 0, 0, 0);
    chk("reset_full", int'(bus.out_full), 0);

    // constant 10.0, six samples back to back
    for (int i = 0; i < 5; i++) push(10 * ONE);
    chk("const_nopulse_valid", int'(bus.out_valid), 0);
    chk("const_nopulse_full", int'(bus.out_full), 0);
    push(10 * ONE);
    chk_stats("const_p1", 1, 10 * ONE, 10 * ONE, 10 * ONE);
    chk("const_p1_full", int'(bus.out_full), 1);
    idle();
    chk_stats("const_p2", 1, 10 * ONE, 10 * ONE, 10 * ONE);
    idle();
    chk_stats("const_p3", 1, 10 * ONE, 10 * ONE, 10 * ONE);
    idle();
    chk_stats("const_hold", 0, 10 * ONE, 10 * ONE, 10 * ONE);
    chk("const_hold_full", int'(bus.out_full), 1);

    // ramp 1.0..5.0 with wrap
    flush();
    push(1 * ONE);
    chk("ramp_clr_full", int'(bus.out_full), 0);
    chk("ramp_clr_avg", int'(bus.out_avg), 0);
    push(2 * ONE);
    push(3 * ONE);
    push(4 * ONE);
    push(5 * ONE);
    idle();
    chk_stats("ramp_w1", 1, 163840, 65536, 262144);
    idle();
    chk_stats("ramp_w2", 1, 229376, 131072, 327680);

    // floor toward minus infinity
    flush();
    push(-1);
    push(0);
    push(0);
    push(0);
    idle();
    idle();
    chk_stats("floor_m1", 1, -1, -1, 0);
    push(-3);
    push(-3);
    push(-3);
    push(-2);
    idle();
    idle();
    chk_stats("floor_m3", 1, -3, -3, -2);

    // gapped samples on cycles 0,3,4,9
    flush();
    push(100);
    idle();
    idle();
    push(200);
    push(-50);
    idle();
    idle();
    chk("gap_c6_valid", int'(bus.out_valid), 0);
    idle();
    idle();
    push(1000);
    idle();
    chk_stats("gap_c10", 0, 0, 0, 0);
    idle();
    chk_stats("gap_c11", 1, 312, -50, 1000);
    idle();
    chk_stats("gap_c12", 0, 312, -50, 1000);

    // clear concurrent with a sample drops that sample
    flush();
    push(7);
    push(7);
    tick(1'b1, 999999, 1'b1, 1'b0);
    push(8);
    chk("clr_full", int'(bus.out_full), 0);
    chk("clr_avg", int'(bus.out_avg), 0);
    push(12);
    push(16);
    push(20);
    chk("clr_s2_valid", int'(bus.out_valid), 0);
    idle();
    chk("clr_s3_valid", int'(bus.out_valid), 0);
    idle();
    chk_stats("clr_s4", 1, 14, 8, 20);

    // extremes, with rst landing on an in-flight update
    flush();
    for (int i = 0; i < 4; i++) push(MAXP);
    idle();
    idle();
    chk_stats("ext_max", 1, MAXP, MAXP, MAXP);
    chk("ext_max_full", int'(bus.out_full), 1);
    push(MAXP);
    tick(1'b0, 0, 1'b0, 1'b1);
    idle();
    chk_stats("ext_rst", 0, 0, 0, 0);
    chk("ext_rst_full", int'(bus.out_full), 0);
    for (int i = 0; i < 4; i++) push(MINN);
    idle();
    idle();
    chk_stats("ext_min", 1, MINN, MINN, MINN);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
